mul_seq_64: RTL

- Iterative shift-and-add multiplier controller for the EX stage MUL instruction.
- Sequences one bitwise-AND partial-product mask and one adder over WIDTH cycles.
- Returns the low WIDTH bits of A*B, matching LEGv8 MUL.
- Replaces a combinational array multiplier. The pipeline stalls on busy and consumes the result on done.

---
 rtl/mul_seq_64.sv | 55 +++++
 1 files changed

// File: rtl/mul_seq_64.sv
// mul_seq_64: iterative shift-and-add multiplier returning the low WIDTH bits of A*B
module mul_seq_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] acc, mcand, mplier, partial, sum;
  logic [CW-1:0] count;
  logic load, last;
  // partial product, accumulation and next-state decode; flush beats start
  always_comb begin
    partial = mcand & {WIDTH{mplier[0]}};
    sum     = acc + partial;
    last    = count == CW'(WIDTH - 1);
    load    = start && !flush && state != RUN;
    state_n = flush ? IDLE : load ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // operand capture, one shift-and-add step per RUN cycle, result latch on the last step
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      result <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= A;
      mplier <= B;
      count  <= '0;
    end else if (state == RUN && !flush) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (last) result <= sum;
    end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule
